// File: rtl/regfile_banked.sv
// Banked register file with a sequential clear engine; R(PC_IDX) reads the r15 input.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_banked #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned BANK_W      = 1,
    parameter int unsigned BANKED_FROM = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] r15,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              clr_busy,
    output logic              wr_drop
);

    localparam int unsigned PC_IDX    = (1 << ADDR_W) - 1;
    localparam int unsigned NUM_BANKS = 1 << BANK_W;
    localparam int unsigned NBANKED   = PC_IDX - BANKED_FROM;
    localparam int unsigned NPHYS     = BANKED_FROM + NUM_BANKS * NBANKED;
    localparam int unsigned IDX_W     = $clog2(NPHYS);

    localparam logic [ADDR_W-1:0] PC_ADDR  = {ADDR_W{1'b1}};
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NPHYS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [NPHYS];
    logic [DATA_W-1:0] mem_d [NPHYS];

    logic              wr_ok;
    logic              byp1, byp2;
    logic [IDX_W-1:0]  wa_phys, ra1_phys, ra2_phys;

    // Banked window: each bank owns a contiguous slice placed after the unbanked entries.
    function automatic logic [IDX_W-1:0] phys_idx(input logic [ADDR_W-1:0] a,
                                                  input logic [BANK_W-1:0] b);
        if (32'(a) < BANKED_FROM)
            return IDX_W'(32'(a));
        return IDX_W'(BANKED_FROM + 32'(b) * NBANKED + (32'(a) - BANKED_FROM));
    endfunction

    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] ra,
                                                   input logic              busy,
                                                   input logic              byp,
                                                   input logic [DATA_W-1:0] pc_val,
                                                   input logic [DATA_W-1:0] fwd,
                                                   input logic [DATA_W-1:0] stored);
        if (ra == PC_ADDR)
            return pc_val;
        if (busy)
            return '0;
        if (byp)
            return fwd;
        return stored;
    endfunction

    assign wr_ok    = we3 && (wa3 != PC_ADDR);
    assign wa_phys  = phys_idx(wa3, bank_sel);
    assign ra1_phys = phys_idx(ra1, bank_sel);
    assign ra2_phys = phys_idx(ra2, bank_sel);

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_ok && (ra1_phys == wa_phys);
    assign byp2 = wr_ok && (ra2_phys == wa_phys);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_drop_d = wr_ok && (state_q == ST_CLEAR);
        mem_d     = mem_q;
        case (state_q)
            ST_IDLE: begin
                // A write in the request cycle still lands; the clear then wipes it.
                if (wr_ok)
                    mem_d[wa_phys] = wd3;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                mem_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign wr_drop  = wr_drop_q;
    assign rd1      = read_mux(ra1, clr_busy, byp1, r15, wd3, mem_q[ra1_phys]);
    assign rd2      = read_mux(ra2, clr_busy, byp2, r15, wd3, mem_q[ra2_phys]);

endmodule

// File: tb/tb_regfile_banked.sv
// Bench for regfile_banked: directed vector table, hand-written clear/reset sequences,
// and randomized traffic against an architectural reference model.
module tb_regfile_banked;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CLR_LEN = 17;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [0:0]  bank_sel;
    logic        we3;
    logic [3:0]  ra1, ra2, wa3;
    logic [31:0] wd3, r15;
    logic        clr_req;
    logic [31:0] rd1, rd2;
    logic        clr_busy, wr_drop;

    int checks = 0;
    int errors = 0;

    regfile_banked dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bank_sel (bank_sel),
        .we3      (we3),
        .ra1      (ra1),
        .ra2      (ra2),
        .wa3      (wa3),
        .wd3      (wd3),
        .r15      (r15),
        .clr_req  (clr_req),
        .rd1      (rd1),
        .rd2      (rd2),
        .clr_busy (clr_busy),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    // Architectural model: one slot per (register, bank) pair; banked registers R13/R14 get key a+16*bank.
    logic [31:0] rm [32];
    bit          rbusy;
    int          rleft;
    bit          rdrop;

    function automatic int key(input logic [3:0] a, input logic [0:0] b);
        if (a == 4'd13 || a == 4'd14)
            return int'(a) + 16 * int'(b);
        return int'(a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] ra);
        if (ra == 4'd15) return r15;
        if (rbusy) return 32'h0;
        if (BYP && we3 && wa3 != 4'd15 && key(ra, bank_sel) == key(wa3, bank_sel)) return wd3;
        return rm[key(ra, bank_sel)];
    endfunction

    task automatic model_reset();
        rbusy = 1'b1;
        rleft = CLR_LEN;
        rdrop = 1'b0;
        for (int i = 0; i < 32; i++) rm[i] = 32'h0;
    endtask

    task automatic model_edge();
        rdrop = we3 && rbusy && (wa3 != 4'd15);
        if (!rbusy) begin
            if (we3 && wa3 != 4'd15) rm[key(wa3, bank_sel)] = wd3;
            if (clr_req) begin
                for (int i = 0; i < 32; i++) rm[i] = 32'h0;
                rbusy = 1'b1;
                rleft = CLR_LEN;
            end
        end else begin
            rleft--;
            if (rleft == 0) rbusy = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rd1"}, rd1, exp_rd(ra1));
        chk({tag, ".rd2"}, rd2, exp_rd(ra2));
        chk({tag, ".busy"}, 32'(clr_busy), 32'(rbusy));
        chk({tag, ".drop"}, 32'(wr_drop), 32'(rdrop));
    endtask

    task automatic count_clear(input string name, input int start, input int want);
        int n;
        n = start;
        while (clr_busy === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(want));
    endtask

    typedef struct {
        logic [0:0]  bank;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1'b0, 1'b1, 4'd13, 32'hAAAA0000, 4'd0,  4'd15, 32'h0,        32'h108};
        tbl[1] = '{1'b1, 1'b1, 4'd13, 32'h5555FFFF, 4'd14, 4'd1,  32'h0,        32'h0};
        tbl[2] = '{1'b0, 1'b1, 4'd5,  32'h12345678, 4'd13, 4'd15, 32'hAAAA0000, 32'h108};
        tbl[3] = '{1'b1, 1'b0, 4'd0,  32'h0,        4'd13, 4'd5,  32'h5555FFFF, 32'h12345678};
        tbl[4] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd5,  4'd13, 32'h12345678, 32'hAAAA0000};
        tbl[5] = '{1'b1, 1'b1, 4'd15, 32'hFFFFFFFF, 4'd15, 4'd14, 32'h108,      32'h0};
        tbl[6] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd14, 4'd12, 32'h0,        32'h0};
        tbl[7] = '{1'b1, 1'b0, 4'd0,  32'h0,        4'd5,  4'd13, 32'h12345678, 32'h5555FFFF};

        reset_n = 1'b0; bank_sel = 1'b0; we3 = 1'b0; ra1 = 4'd3; ra2 = 4'd15;
        wa3 = 4'd0; wd3 = 32'h0; r15 = 32'h108; clr_req = 1'b0;
        model_reset();

        // Reset state and power-up clear length
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2_pc", rd2, 32'h108);
        chk("rst_busy", 32'(clr_busy), 32'h1);
        chk("rst_drop", 32'(wr_drop), 32'h0);
        reset_n = 1'b1;
        count_clear("por_clear_len", 0, CLR_LEN);
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 15; a++) begin
                bank_sel = 1'(b); ra1 = 4'(a); ra2 = 4'(14 - a);
                #1;
                chk("por_zero_rd1", rd1, 32'h0);
                chk("por_zero_rd2", rd2, 32'h0);
            end
        end

        // Directed vector table: banked and unbanked writes, PC reads, PC write ignored
        for (int i = 0; i < 8; i++) begin
            bank_sel = tbl[i].bank; we3 = tbl[i].we; wa3 = tbl[i].wa; wd3 = tbl[i].wd;
            ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, tbl[i].rd1);
            chk($sformatf("vec%0d_rd2", i), rd2, tbl[i].rd2);
            tick();
            chk($sformatf("vec%0d_drop", i), 32'(wr_drop), 32'h0);
        end
        we3 = 1'b0;

        // Clear request with a same-cycle write, then a dropped write during the clear
        bank_sel = 1'b0; we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hDEAD; clr_req = 1'b1;
        ra1 = 4'd3; ra2 = 4'd15;
        #1;
        chk("clrreq_rd1", rd1, BYP ? 32'hDEAD : 32'h0);
        tick();
        we3 = 1'b0; clr_req = 1'b0;
        #1;
        chk("clr_busy_on", 32'(clr_busy), 32'h1);
        chk("clr_rd1_zero", rd1, 32'h0);
        tick();
        we3 = 1'b1; wa3 = 4'd4; wd3 = 32'hBEEF;
        tick();
        we3 = 1'b0;
        chk("clr_drop_pulse", 32'(wr_drop), 32'h1);
        tick();
        chk("clr_drop_end", 32'(wr_drop), 32'h0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        count_clear("req_clear_len", 4, CLR_LEN);
        ra1 = 4'd3; ra2 = 4'd4;
        #1;
        chk("clr_r3_zero", rd1, 32'h0);
        chk("clr_r4_zero", rd2, 32'h0);

        // Reset during a clear restarts it from the beginning
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (6) tick();
        we3 = 1'b1; wa3 = 4'd2; wd3 = 32'h77;
        tick();
        we3 = 1'b0;
        chk("mid_drop_pulse", 32'(wr_drop), 32'h1);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy", 32'(clr_busy), 32'h1);
        chk("mid_rst_drop", 32'(wr_drop), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_clear("restart_clear_len", 0, CLR_LEN);

        // Write-to-read forwarding behaviour
        bank_sel = 1'b0; we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h11111111;
        tick();
        wd3 = 32'hCAFEF00D; ra1 = 4'd7; ra2 = 4'd15;
        #1;
        chk("byp_same_cycle", rd1, BYP ? 32'hCAFEF00D : 32'h11111111);
        chk("byp_pc_prio", rd2, 32'h108);
        tick();
        we3 = 1'b0;
        #1;
        chk("byp_next_cycle", rd1, 32'hCAFEF00D);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            bank_sel = 1'($urandom_range(1));
            we3      = 1'($urandom_range(1));
            wa3      = 4'($urandom_range(15));
            ra1      = ($urandom_range(3) == 0) ? wa3 : 4'($urandom_range(15));
            ra2      = 4'($urandom_range(15));
            wd3      = $urandom;
            r15      = $urandom;
            clr_req  = ($urandom_range(59) == 0);
            #1;
            check_outputs($sformatf("rand%0d", i));
            tick();
        end
        clr_req = 1'b0; we3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
- Parametrised successor to the processor's flat 16-entry register file; used by the multi-cycle datapath.
- Adds mode-banked upper registers: with defaults, R13 and R14 have one copy per bank, selected by `bank_sel`.
- Adds a sequential clear engine that zeroes every physical entry after reset or on request, plus an optional same-cycle write-to-read bypass.
- The PC index is not stored; reading it returns the `r15` input.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, architectural address width; PC_IDX = 2**ADDR_W-1.
- BANK_W, 1, bank-select width; NUM_BANKS = 2**BANK_W.
- BANKED_FROM, 13, first banked architectural index; indices BANKED_FROM..PC_IDX-1 are banked. Legal range: 1..PC_IDX.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bank_sel  in  BANK_W  bank applied to ra1, ra2 and wa3 in the same cycle.
- we3  in  1  write enable.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- wa3  in  ADDR_W  write address.
- wd3  in  DATA_W  write data.
- r15  in  DATA_W  PC+8 value returned for reads of PC_IDX.
- clr_req  in  1  request a full clear; sampled only in IDLE.
- rd1  out  DATA_W  read data, port 1; combinational.
- rd2  out  DATA_W  read data, port 2; combinational.
- clr_busy  out  1  high while the clear engine runs.
- wr_drop  out  1  registered one-cycle pulse: a write was discarded during a clear.

Behaviour:
- Physical depth: NPHYS = BANKED_FROM + NUM_BANKS*(PC_IDX-BANKED_FROM). Defaults give 17 entries.
- Address map:
  - a < BANKED_FROM -> physical index a.
  - BANKED_FROM <= a < PC_IDX -> BANKED_FROM + bank_sel*(PC_IDX-BANKED_FROM) + (a-BANKED_FROM).
  - a == PC_IDX -> not stored.
- Reads: rdN = r15 if raN == PC_IDX; else 0 when clr_busy=1; else mem[map(raN)].
- Writes: on the rising clk edge when we3=1, state=IDLE and wa3 != PC_IDX, mem[map(wa3)] <= wd3.
  - we3=1 with wa3 == PC_IDX is silently ignored and does not pulse wr_drop.
- Clear FSM, two states: IDLE and CLEAR; index counter idx has width clog2(NPHYS).
  - reset_n low (asynchronous): state=CLEAR, idx=0, clr_busy=1, wr_drop=0. Memory contents are not reset directly; the engine clears them.
  - CLEAR, each edge: mem[idx] <= 0.
    - If idx == NPHYS-1: go to IDLE and set idx=0.
    - Otherwise idx <= idx+1.
    - Duration is exactly NPHYS cycles after reset release.
  - IDLE with clr_req=1: go to CLEAR next edge, idx=0.
    - If we3=1 in that same cycle, the write still commits, then gets cleared.
  - clr_req in CLEAR is ignored; no restart, no extension.
  - reset_n asserted mid-clear restarts the clear at idx=0.
- clr_busy = (state == CLEAR), registered.
- wr_drop <= we3 & (state==CLEAR) & (wa3 != PC_IDX). Its reset value is 0.
- Output reset values: clr_busy=1. rd1/rd2 read 0 except at PC_IDX, which returns r15. wr_drop=0.
- bank_sel changes take effect on reads in the same cycle. Unbanked indices ignore bank_sel.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE, when we3=1, wa3 != PC_IDX and map(raN)==map(wa3) under the current bank_sel, rdN returns wd3 in the same cycle.
- Undefined: rdN returns the old contents until the edge after the write.
- The PC_IDX read rule and the clear-zero read rule take priority over the bypass in both builds.

Test Plan:
- Reset release, defaults: clr_busy stays 1 for exactly 17 cycles, then 0. Every R0..R14 in both banks then reads 0.
- bank_sel=0, write R13=0xAAAA0000; bank_sel=1, write R13=0x5555FFFF. bank_sel=0 reads 0xAAAA0000, bank_sel=1 reads 0x5555FFFF. A write of R5=0x12345678 reads back the same in both banks.
- r15=0x00000108, ra1=15, ra2=15 -> rd1=rd2=0x108. A write with wa3=15 leaves all entries unchanged and wr_drop=0.
- clr_req=1 with we3=1, wa3=3, wd3=0xDEAD in IDLE: R3 commits, then clr_busy=1 for 17 cycles, then R3 reads 0. A write to R4 on cycle 2 of the clear gives a wr_drop pulse on the next cycle and R4 stays 0.
- Reset asserted at cycle 8 of a clear, released 2 cycles later: clr_busy stays 1 for a fresh 17 cycles after release.
- Bypass: with the macro defined, we3=1, wa3=ra1=7, wd3=0xCAFEF00D gives rd1=0xCAFEF00D in the same cycle. With it undefined, rd1 shows the old value that cycle and 0xCAFEF00D the next.
